// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier, K bits/cycle; out_valid N+1 clocks after accept, result held until out_ready.
// Define MUL_SIGNED_EN to add the signed_op port (magnitudes multiplied, sign applied on DONE entry).
module shift_add_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MUL_SIGNED_EN
  input  logic                 signed_op,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  generate
    if ((BITS_PER_CYCLE < 1) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_k
      $fatal(1, "BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   w_partial;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_BUSY) && (r_count == CW'(N));

`ifdef MUL_SIGNED_EN
  // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign w_a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
  assign w_neg   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
  assign w_neg   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_BUSY;
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state == S_BUSY);
    out_valid = (r_state == S_DONE);
  end

  always_comb begin
    w_partial = '0;
    for (int k = 0; k < K; k++) begin
      if (r_mplier[k]) w_partial = w_partial + (r_mcand << k);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      result   <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= w_neg;
    end else if (r_state == S_BUSY) begin
      // All N steps are done by the time count reaches N; this cycle only publishes.
      if (w_last) begin
        result <= r_neg ? -r_acc : r_acc;
      end else begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << K;
        r_mplier <= r_mplier >> K;
        r_count  <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Two instances (K=1 and K=4, WIDTH=32) driven with directed and random ops against an arithmetic model.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] a         [2];
  logic [31:0] b         [2];
  logic        signed_op [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [63:0] result    [2];
  logic        busy      [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_k1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]),
`ifdef MUL_SIGNED_EN
    .signed_op(signed_op[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
  );

  shift_add_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_k4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]),
`ifdef MUL_SIGNED_EN
    .signed_op(signed_op[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sp;
    logic [63:0]        up;
    up = {32'b0, x} * {32'b0, y};
`ifdef MUL_SIGNED_EN
    if (s) begin
      sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      up = sp;
    end
`else
    if (s) up = up;
`endif
    return up;
  endfunction

  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic sgn, input int hold, input string tag);
    logic [63:0] exp;
    int          lat;
    int          want_lat;
    exp      = model(av, bv, sgn);
    want_lat = (d == 0) ? 33 : 9;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 64'(in_ready[d]), 64'd1);
    in_valid[d]  = 1'b1;
    a[d]         = av;
    b[d]         = bv;
    signed_op[d] = sgn;
    @(posedge clk);
    #1;
    in_valid[d]  = 1'b0;
    a[d]         = $urandom;
    b[d]         = $urandom;
    signed_op[d] = 1'($urandom);
    chk({tag, "_busy"}, 64'(busy[d]), 64'd1);
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (out_valid[d]) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(want_lat));
    chk({tag, "_result"}, result[d], exp);
    for (int h = 0; h < hold; h++) begin
      in_valid[d] = 1'b1;
      a[d]        = $urandom;
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 64'(out_valid[d]), 64'd1);
      chk({tag, "_hold_result"}, result[d], exp);
      chk({tag, "_hold_in_ready"}, 64'(in_ready[d]), 64'd0);
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid[d]), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(in_ready[d]), 64'd1);
    chk({tag, "_result_kept"}, result[d], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      a[d]         = '0;
      b[d]         = '0;
      signed_op[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    #23;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 64'(in_ready[d]), 64'd1);
      chk("reset_out_valid", 64'(out_valid[d]), 64'd0);
      chk("reset_busy", 64'(busy[d]), 64'd0);
      chk("reset_result", result[d], 64'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    run_op(0, 32'd9999, 32'd9999, 1'b0, 0, "k1_9999sq");
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, "k4_maxsq");
    chk("k4_maxsq_const", result[1], 64'hFFFF_FFFE_0000_0001);
    run_op(1, 32'd0, 32'h1234_5678, 1'b0, 1, "k4_zero");
    run_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2, "k1_by_one");

    // Abort an op part way through BUSY with an asynchronous reset.
    @(negedge clk);
    in_valid[0] = 1'b1;
    a[0]        = 32'd123456;
    b[0]        = 32'd777;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midreset_in_ready", 64'(in_ready[0]), 64'd1);
    chk("midreset_busy", 64'(busy[0]), 64'd0);
    chk("midreset_result", result[0], 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(0, 32'd3, 32'd5, 1'b0, 0, "after_reset_3x5");
    chk("after_reset_15", result[0], 64'd15);

`ifdef MUL_SIGNED_EN
    run_op(0, 32'hFFFF_FFFD, 32'd7, 1'b1, 0, "s_neg3x7");
    chk("s_neg3x7_const", result[0], 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1, "s_minsq");
    chk("s_minsq_const", result[1], 64'h4000_0000_0000_0000);
    run_op(1, 32'h8000_0000, 32'd1, 1'b1, 0, "s_min_x1");
`endif

    for (int i = 0; i < 8; i++) begin
      run_op(i % 2, $urandom, $urandom, 1'($urandom), i % 3, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
